// File: rtl/bp_be_pkg.sv
// Backend shared types: writeback source indices and clear-port geometry.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  typedef enum logic [2:0] {
    e_wb_src_div,
    e_wb_src_fpu,
    e_wb_src_dfill,
    e_wb_src_ptw
  } bp_be_wb_src_e;

  localparam int wb_clear_ports_gp = 2;
  localparam int reg_addr_width_gp = 5;

  function automatic int reg_addr_width_f(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return reg_addr_width_gp;
      default:          return reg_addr_width_gp;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_clear_arbiter_di_if.sv
// Completion sources in, dual scoreboard clear ports out.
interface bp_be_clear_arbiter_di_if #(
  parameter int num_src_p = 4,
  parameter int rd_w_p    = 5
);
  logic [num_src_p-1:0]        src_v_i;
  logic [num_src_p*rd_w_p-1:0] src_rd_i;
  logic [num_src_p-1:0]        src_ready_and_o;
  logic                        clear_v_o;
  logic [rd_w_p-1:0]           clear_rd_o;
  logic                        clear_v_o2;
  logic [rd_w_p-1:0]           clear_rd_o2;
  logic                        idle_o;

  modport slave (
    input  src_v_i, src_rd_i,
    output src_ready_and_o,
    output clear_v_o, clear_rd_o,
    output clear_v_o2, clear_rd_o2,
    output idle_o
  );

  modport master (
    output src_v_i, src_rd_i,
    input  src_ready_and_o,
    input  clear_v_o, clear_rd_o,
    input  clear_v_o2, clear_rd_o2,
    input  idle_o
  );
endinterface

// File: rtl/bp_be_rr_pick2.sv
// Round-robin picker: first two valid requesters starting at ptr_i.
module bp_be_rr_pick2
  import bp_be_pkg::*;
#(
  parameter  int num_src_p = 4,
  localparam int ptr_w_lp  = $clog2(num_src_p)
) (
  input  logic [num_src_p-1:0] v_i,
  input  logic [ptr_w_lp-1:0]  ptr_i,
  output logic [num_src_p-1:0] gnt0_o,
  output logic [num_src_p-1:0] gnt1_o,
  output logic                 v0_o,
  output logic                 v1_o,
  output logic [ptr_w_lp-1:0]  idx0_o,
  output logic [ptr_w_lp-1:0]  idx1_o,
  output logic [ptr_w_lp-1:0]  last_o
);

  localparam logic [ptr_w_lp:0] n_lp = (ptr_w_lp+1)'(num_src_p);

  logic [ptr_w_lp:0]   w_idx;
  logic [ptr_w_lp-1:0] w_sel;
  int                  w_cnt;

  always_comb begin
    gnt0_o = '0;
    gnt1_o = '0;
    v0_o   = 1'b0;
    v1_o   = 1'b0;
    idx0_o = '0;
    idx1_o = '0;
    w_idx  = '0;
    w_sel  = '0;
    w_cnt  = 0;
    for (int k = 0; k < num_src_p; k++) begin
      // explicit wrap so non-power-of-2 source counts stay in range
      w_idx = {1'b0, ptr_i} + (ptr_w_lp+1)'(k);
      if (w_idx >= n_lp)
        w_idx = w_idx - n_lp;
      w_sel = w_idx[ptr_w_lp-1:0];
      if (v_i[w_sel] && (w_cnt < wb_clear_ports_gp)) begin
        if (w_cnt == 0) begin
          gnt0_o[w_sel] = 1'b1;
          v0_o          = 1'b1;
          idx0_o        = w_sel;
        end else begin
          gnt1_o[w_sel] = 1'b1;
          v1_o          = 1'b1;
          idx1_o        = w_sel;
        end
        w_cnt = w_cnt + 1;
      end
    end
    last_o = v1_o ? idx1_o : idx0_o;
  end

endmodule

// File: rtl/bp_be_clear_arbiter_di.sv
// Dual-issue scoreboard clear arbiter: RR-picks two completions per
// cycle, filters x0 and same-rd pairs, registers the clear ports.
module bp_be_clear_arbiter_di
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int         num_src_p   = 4
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  bp_be_clear_arbiter_di_if.slave io
);

  localparam int rd_w_lp  = reg_addr_width_f(bp_params_p);
  localparam int ptr_w_lp = $clog2(num_src_p);
  localparam logic [ptr_w_lp-1:0] last_src_lp =
    ptr_w_lp'(num_src_p-1);

  logic [ptr_w_lp-1:0]  r_ptr;
  logic                 r_v;
  logic [rd_w_lp-1:0]   r_rd;
  logic                 r_v2;
  logic [rd_w_lp-1:0]   r_rd2;

  logic [num_src_p-1:0] w_gnt0;
  logic [num_src_p-1:0] w_gnt1;
  logic                 w_v0;
  logic                 w_v1;
  logic [ptr_w_lp-1:0]  w_idx0;
  logic [ptr_w_lp-1:0]  w_idx1;
  logic [ptr_w_lp-1:0]  w_last;
  logic [ptr_w_lp-1:0]  w_ptr_nxt;
  logic [rd_w_lp-1:0]   w_rd0;
  logic [rd_w_lp-1:0]   w_rd1;
  logic                 w_a;
  logic                 w_b;

  bp_be_rr_pick2 #(
    .num_src_p(num_src_p)
  ) u_pick (
    .v_i   (io.src_v_i),
    .ptr_i (r_ptr),
    .gnt0_o(w_gnt0),
    .gnt1_o(w_gnt1),
    .v0_o  (w_v0),
    .v1_o  (w_v1),
    .idx0_o(w_idx0),
    .idx1_o(w_idx1),
    .last_o(w_last)
  );

  assign w_rd0 = io.src_rd_i[w_idx0*rd_w_lp +: rd_w_lp];
  assign w_rd1 = io.src_rd_i[w_idx1*rd_w_lp +: rd_w_lp];

  // x0 is never scored; a same-rd pair needs only one clear
  assign w_a = w_v0 & (|w_rd0);
  assign w_b = w_v1 & (|w_rd1) & ~(w_a & (w_rd1 == w_rd0));

  assign w_ptr_nxt = (w_last == last_src_lp) ? '0
                                             : w_last + 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr <= '0;
      r_v   <= 1'b0;
      r_rd  <= '0;
      r_v2  <= 1'b0;
      r_rd2 <= '0;
    end else begin
      if (w_v0)
        r_ptr <= w_ptr_nxt;
      r_v   <= w_a | w_b;
      r_rd  <= w_a ? w_rd0 : (w_b ? w_rd1 : '0);
      r_v2  <= w_a & w_b;
      r_rd2 <= (w_a & w_b) ? w_rd1 : '0;
    end
  end

  assign io.src_ready_and_o = reset_n_i ? (w_gnt0 | w_gnt1) : '0;
  assign io.clear_v_o       = r_v;
  assign io.clear_rd_o      = r_rd;
  assign io.clear_v_o2      = r_v2;
  assign io.clear_rd_o2     = r_rd2;
  assign io.idle_o          = ~reset_n_i |
                              (~(|io.src_v_i) & ~r_v & ~r_v2);

endmodule

// File: tb/tb_bp_be_clear_arbiter_di.sv
// Vector table + scoreboard bench for the dual clear arbiter.
module tb_bp_be_clear_arbiter_di;
  import bp_be_pkg::*;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int NV = 14;

  typedef struct {
    logic [N-1:0]   v;
    logic [N*W-1:0] rd;
    logic [N-1:0]   rdy;
    logic           c0v;
    logic [W-1:0]   c0;
    logic           c1v;
    logic [W-1:0]   c1;
  } vec_t;

  typedef struct packed {
    logic         c0v;
    logic [W-1:0] c0;
    logic         c1v;
    logic [W-1:0] c1;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [NV];
  exp_t q [$];
  exp_t e;

  always #5 clk = ~clk;

  bp_be_clear_arbiter_di_if #(.num_src_p(N), .rd_w_p(W)) bus ();

  bp_be_clear_arbiter_di #(
    .bp_params_p(e_bp_default_cfg),
    .num_src_p  (N)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .io       (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] v,
    input logic [4:0] r3, input logic [4:0] r2,
    input logic [4:0] r1, input logic [4:0] r0,
    input logic [3:0] rdy,
    input logic c0v, input logic [4:0] c0,
    input logic c1v, input logic [4:0] c1);
    vec_t t;
    t.v   = v;
    t.rd  = {r3, r2, r1, r0};
    t.rdy = rdy;
    t.c0v = c0v;
    t.c0  = c0;
    t.c1v = c1v;
    t.c1  = c1;
    return t;
  endfunction

  initial begin
    // rr_ptr walk: 0 3 1 0 2 0 2 2 0 2 1 1 1 0 -> 2
    tbl[0]  = mk(4'b0100, 0, 7, 0, 0,  4'b0100, 1, 7,  0, 0);
    tbl[1]  = mk(4'b1001, 9, 0, 0, 5,  4'b1001, 1, 9,  1, 5);
    tbl[2]  = mk(4'b1000, 6, 0, 0, 0,  4'b1000, 1, 6,  0, 0);
    tbl[3]  = mk(4'b1111, 4, 3, 2, 1,  4'b0011, 1, 1,  1, 2);
    tbl[4]  = mk(4'b1111, 4, 3, 2, 1,  4'b1100, 1, 3,  1, 4);
    tbl[5]  = mk(4'b1111, 4, 3, 2, 1,  4'b0011, 1, 1,  1, 2);
    tbl[6]  = mk(4'b0000, 0, 0, 0, 0,  4'b0000, 0, 0,  0, 0);
    tbl[7]  = mk(4'b1100, 12, 0, 0, 0, 4'b1100, 1, 12, 0, 0);
    tbl[8]  = mk(4'b0011, 0, 0, 12, 12, 4'b0011, 1, 12, 0, 0);
    tbl[9]  = mk(4'b0001, 0, 0, 0, 0,  4'b0001, 0, 0,  0, 0);
    tbl[10] = mk(4'b0101, 0, 8, 0, 8,  4'b0101, 1, 8,  0, 0);
    tbl[11] = mk(4'b0011, 0, 0, 0, 0,  4'b0011, 0, 0,  0, 0);
    tbl[12] = mk(4'b1010, 17, 0, 31, 0, 4'b1010, 1, 31, 1, 17);
    tbl[13] = mk(4'b0010, 0, 0, 5, 0,  4'b0010, 1, 5,  0, 0);

    bus.src_v_i  = 4'hF;
    bus.src_rd_i = {5'd4, 5'd3, 5'd2, 5'd1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.src_ready_and_o), 0);
    chk("rst_v",     32'(bus.clear_v_o), 0);
    chk("rst_v2",    32'(bus.clear_v_o2), 0);
    chk("rst_rd",    32'(bus.clear_rd_o), 0);
    chk("rst_rd2",   32'(bus.clear_rd_o2), 0);
    chk("rst_idle",  32'(bus.idle_o), 1);

    @(negedge clk);
    rst_n       = 1'b1;
    bus.src_v_i = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.src_v_i  = tbl[i].v;
      bus.src_rd_i = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_ready", i),
          32'(bus.src_ready_and_o), 32'(tbl[i].rdy));
      if (i == 6)
        chk("idle_busy", 32'(bus.idle_o), 0);
      q.push_back('{tbl[i].c0v, tbl[i].c0, tbl[i].c1v, tbl[i].c1});
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", i), 1, 0);
      end else begin
        e = q.pop_front();
        chk($sformatf("v%0d_cv", i),  32'(bus.clear_v_o), 32'(e.c0v));
        chk($sformatf("v%0d_crd", i), 32'(bus.clear_rd_o), 32'(e.c0));
        chk($sformatf("v%0d_cv2", i), 32'(bus.clear_v_o2), 32'(e.c1v));
        chk($sformatf("v%0d_crd2", i),
            32'(bus.clear_rd_o2), 32'(e.c1));
      end
      chk($sformatf("v%0d_order", i),
          32'(bus.clear_v_o2 & ~bus.clear_v_o), 0);
      if (i == 6)
        chk("idle_quiet", 32'(bus.idle_o), 1);
    end

    @(negedge clk);
    bus.src_v_i = '0;
    #1;
    chk("idle_drain", 32'(bus.idle_o), 0);
    @(posedge clk);
    #1;
    chk("idle_after", 32'(bus.idle_o), 1);

    // async reset lands while a clear is on the port
    @(negedge clk);
    bus.src_v_i  = 4'b0001;
    bus.src_rd_i = {5'd0, 5'd0, 5'd0, 5'd9};
    #1;
    chk("mid_ready", 32'(bus.src_ready_and_o), 32'(4'b0001));
    @(posedge clk);
    #1;
    chk("mid_cv",  32'(bus.clear_v_o), 1);
    chk("mid_crd", 32'(bus.clear_rd_o), 9);
    bus.src_v_i  = 4'hF;
    bus.src_rd_i = {5'd4, 5'd3, 5'd2, 5'd1};
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cv",    32'(bus.clear_v_o), 0);
    chk("mid_rst_ready", 32'(bus.src_ready_and_o), 0);
    chk("mid_rst_idle",  32'(bus.idle_o), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.src_ready_and_o), 32'(4'b0011));
    @(posedge clk);
    #1;
    chk("post_rst_crd",  32'(bus.clear_rd_o), 1);
    chk("post_rst_crd2", 32'(bus.clear_rd_o2), 2);
    chk("post_rst_cv2",  32'(bus.clear_v_o2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
